// File: rtl/alien_march_sequencer_if.sv
// alien_march_sequencer_if: step-command bundle between the march sequencer and AliensMotion.
// master = sequencer (issues motion), slave = the swarm/game side feeding status back.
interface alien_march_sequencer_if #(parameter int PW = 24);
    logic enable;
    logic canLeft;
    logic canRight;
    logic killingAlien;
    logic victory;
    logic defeat;
    logic [1:0] motion;
    logic stepPulse;
    logic dirLeft;
    logic [PW-1:0] period;
    modport master (
        input enable, canLeft, canRight, killingAlien, victory, defeat,
        output motion, stepPulse, dirLeft, period
    );
    modport slave (
        output enable, canLeft, canRight, killingAlien, victory, defeat,
        input motion, stepPulse, dirLeft, period
    );
endinterface

// File: rtl/alien_march_sequencer.sv
// alien_march_sequencer: issues one-cycle LEFT/RIGHT/DOWN swarm steps, speeding up on each kill.
// motion codes: 0=none, 1=LEFT, 2=RIGHT, 3=DOWN.
module alien_march_sequencer #(
    parameter int TICK_DIV    = 2000000,
    parameter int MIN_DIV     = 200000,
    parameter int SPEEDUP_DIV = 50000,
    parameter int PW          = 24
) (
    input logic clk,
    input logic reset,
    alien_march_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, MARCH, HALT} stateT;
    // One bit wider than the period so a shrink below zero saturates instead of wrapping.
    localparam logic [PW:0] SHRINK_FLOOR = (PW+1)'(MIN_DIV + SPEEDUP_DIV);
    stateT state;
    logic [PW-1:0] cnt;
    logic killPrev;
    logic stop;
    logic killEvent;
    logic termCnt;
    logic blocked;
    logic [PW-1:0] shrunk;
    always_comb begin
        stop = bus.victory | bus.defeat;
        killEvent = bus.killingAlien & ~killPrev & (state != HALT);
        termCnt = cnt >= bus.period - 1'b1;
        blocked = bus.dirLeft ? ~bus.canLeft : ~bus.canRight;
        shrunk = ({1'b0, bus.period} < SHRINK_FLOOR) ? PW'(MIN_DIV) : bus.period - PW'(SPEEDUP_DIV);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            killPrev <= 1'b0;
            bus.motion <= 2'd0;
            bus.stepPulse <= 1'b0;
            bus.dirLeft <= 1'b0;
            bus.period <= PW'(TICK_DIV);
        end else begin
            killPrev <= bus.killingAlien;
            bus.motion <= 2'd0;
            bus.stepPulse <= 1'b0;
            if (killEvent)
                bus.period <= shrunk;
            // Halting wins over a step decided in the same cycle.
            if (stop) begin
                state <= HALT;
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (bus.enable)
                            state <= MARCH;
                    end
                    MARCH: begin
                        if (!bus.enable) begin
                            state <= IDLE;
                            cnt <= '0;
                        end else if (termCnt) begin
                            cnt <= '0;
                            bus.motion <= blocked ? 2'd3 : (bus.dirLeft ? 2'd1 : 2'd2);
                            bus.stepPulse <= 1'b1;
                            if (blocked)
                                bus.dirLeft <= ~bus.dirLeft;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: cnt <= '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alien_march_sequencer.sv
// tb_alien_march_sequencer: directed checks of step timing, direction, speed-up, halt and reset.
module tb_alien_march_sequencer;
    logic clk = 1'b0;
    logic reset;
    int cyc = 0;
    int nCompared = 0;
    int nMismatched = 0;
    int t0, t1, t2, m, sawStep;
    alien_march_sequencer_if #(.PW(8)) bus ();
    alien_march_sequencer #(.TICK_DIV(8), .MIN_DIV(4), .SPEEDUP_DIV(3), .PW(8)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string tag, input int got, input int exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    // Waits for the next nonzero motion; returns the cycle stamp and code, then checks it is one cycle wide.
    task automatic waitStep(input string tag, output int t, output int mo);
        mo = 0;
        t = cyc;
        for (int i = 0; i < 40 && mo == 0; i++) begin
            @(negedge clk);
            mo = int'(bus.motion);
            t = cyc;
        end
        check({tag, " found"}, int'(mo != 0), 1);
        check({tag, " pulse"}, int'(bus.stepPulse), int'(mo != 0));
        @(negedge clk);
        check({tag, " width"}, int'(bus.motion), 0);
    endtask
    initial begin
        reset = 1'b0;
        bus.enable = 1'b0;
        bus.canLeft = 1'b1;
        bus.canRight = 1'b1;
        bus.killingAlien = 1'b0;
        bus.victory = 1'b0;
        bus.defeat = 1'b0;
        repeat (2) @(negedge clk);
        check("rst motion", int'(bus.motion), 0);
        check("rst pulse", int'(bus.stepPulse), 0);
        check("rst dir", int'(bus.dirLeft), 0);
        check("rst period", int'(bus.period), 8);
        // Right march: one cycle to leave IDLE, then a full period of counting.
        reset = 1'b1;
        bus.enable = 1'b1;
        t0 = cyc;
        waitStep("r1", t1, m);
        check("r1 latency", t1 - t0, 9);
        check("r1 motion", m, 2);
        check("r1 dir", int'(bus.dirLeft), 0);
        waitStep("r2", t2, m);
        check("r2 spacing", t2 - t1, 8);
        check("r2 motion", m, 2);
        bus.canRight = 1'b0;
        waitStep("wallR", t1, m);
        check("wallR spacing", t1 - t2, 8);
        check("wallR motion", m, 3);
        check("wallR dir", int'(bus.dirLeft), 1);
        waitStep("l1", t2, m);
        check("l1 spacing", t2 - t1, 8);
        check("l1 motion", m, 1);
        check("l1 dir", int'(bus.dirLeft), 1);
        bus.canRight = 1'b1;
        // Speed-up: a held kill counts once, then saturation at the floor.
        bus.killingAlien = 1'b1;
        repeat (5) @(negedge clk);
        bus.killingAlien = 1'b0;
        check("kill1 period", int'(bus.period), 5);
        @(negedge clk);
        bus.killingAlien = 1'b1;
        @(negedge clk);
        bus.killingAlien = 1'b0;
        check("kill2 period", int'(bus.period), 4);
        @(negedge clk);
        bus.killingAlien = 1'b1;
        @(negedge clk);
        bus.killingAlien = 1'b0;
        check("kill3 period", int'(bus.period), 4);
        waitStep("fastA", t1, m);
        waitStep("fastB", t2, m);
        check("fast spacing", t2 - t1, 4);
        check("fast motion", m, 1);
        // Both walls blocked: only DOWN steps, direction toggling.
        bus.canLeft = 1'b0;
        bus.canRight = 1'b0;
        waitStep("d1", t1, m);
        check("d1 motion", m, 3);
        check("d1 dir", int'(bus.dirLeft), 0);
        waitStep("d2", t1, m);
        check("d2 motion", m, 3);
        check("d2 dir", int'(bus.dirLeft), 1);
        waitStep("d3", t1, m);
        check("d3 motion", m, 3);
        check("d3 dir", int'(bus.dirLeft), 0);
        // Pause mid-count, then resume: next step a full period after re-enable.
        bus.canLeft = 1'b1;
        bus.enable = 1'b0;
        sawStep = 0;
        repeat (3) begin
            @(negedge clk);
            sawStep += int'(bus.motion != 0);
        end
        check("pause steps", sawStep, 0);
        bus.enable = 1'b1;
        t0 = cyc;
        waitStep("resume", t1, m);
        check("resume latency", t1 - t0, 5);
        check("resume motion", m, 3);
        check("resume dir", int'(bus.dirLeft), 1);
        m = 0;
        for (int i = 0; i < 20 && m == 0; i++) begin
            @(negedge clk);
            m = int'(bus.motion);
        end
        check("pre-reset motion", m, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst motion", int'(bus.motion), 0);
        check("midrst pulse", int'(bus.stepPulse), 0);
        check("midrst dir", int'(bus.dirLeft), 0);
        check("midrst period", int'(bus.period), 8);
        @(negedge clk);
        check("rsthold motion", int'(bus.motion), 0);
        // Defeat coincident with terminal count suppresses the step and halts for good.
        bus.canRight = 1'b1;
        reset = 1'b1;
        t0 = cyc;
        waitStep("h0", t1, m);
        check("h0 latency", t1 - t0, 9);
        repeat (6) @(negedge clk);
        bus.defeat = 1'b1;
        @(negedge clk);
        bus.defeat = 1'b0;
        check("halt edge motion", int'(bus.motion), 0);
        sawStep = 0;
        for (int i = 0; i < 30; i++) begin
            if (i % 5 == 0)
                bus.enable = ~bus.enable;
            bus.killingAlien = (i % 4) < 2;
            @(negedge clk);
            sawStep += int'(bus.motion != 0) + int'(bus.stepPulse);
        end
        check("halt steps", sawStep, 0);
        check("halt period", int'(bus.period), 8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
